// File: rtl/regfile_pkg.sv
// Shared sizing constants for the register file.
// Defines DATA_W, ADDR_W and NUM_REGS.
package regfile_pkg;

   localparam int DATA_W   = 16;
   localparam int ADDR_W   = 4;
   localparam int NUM_REGS = 2 ** ADDR_W;

endpackage

// File: rtl/regfile_read_port.sv
// Combinational read port: selects one register by address.
// Ports: regs (flattened register array), addr (index), data (selected value).
import regfile_pkg::*;

module regfile_read_port #(
   parameter int DATA_W = regfile_pkg::DATA_W,
   parameter int ADDR_W = regfile_pkg::ADDR_W
) (
   input  logic [(2**ADDR_W)-1:0][DATA_W-1:0] regs,
   input  logic [ADDR_W-1:0]                  addr,
   output logic [DATA_W-1:0]                  data
);

   // Every ADDR_W-bit address maps to a register, so no range check.
   assign data = regs[addr];

endmodule

// File: rtl/register_file.sv
// Two-read, one-write register file with synchronous active-high reset.
// Ports: clk, rst, Rs/Rt (read addrs), Rd/RW/wr (write), Rout1/Rout2 (reads).
import regfile_pkg::*;

module register_file #(
   parameter int DATA_W = regfile_pkg::DATA_W,
   parameter int ADDR_W = regfile_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] Rs,
   input  logic [ADDR_W-1:0] Rt,
   input  logic [ADDR_W-1:0] Rd,
   input  logic [DATA_W-1:0] RW,
   input  logic              wr,
   output logic [DATA_W-1:0] Rout1,
   output logic [DATA_W-1:0] Rout2
);

   localparam int NREGS = 2 ** ADDR_W;

   logic [NREGS-1:0][DATA_W-1:0] regs;

   // Reset wins over a concurrent write; address 0 is an ordinary register.
   always_ff @(posedge clk) begin
      if (rst) begin
         regs <= '0;
      end else if (wr) begin
         regs[Rd] <= RW;
      end
   end

   // Reads see stored state only: a same-address write shows after the edge.
   regfile_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_read1 (
      .regs (regs),
      .addr (Rs),
      .data (Rout1)
   );

   regfile_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_read2 (
      .regs (regs),
      .addr (Rt),
      .data (Rout2)
   );

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file.
// Drives hand-computed vectors and compares both read ports.
module tb_register_file;

   logic        clk;
   logic        rst;
   logic [3:0]  Rs;
   logic [3:0]  Rt;
   logic [3:0]  Rd;
   logic [15:0] RW;
   logic        wr;
   logic [15:0] Rout1;
   logic [15:0] Rout2;

   int checks;
   int errors;

   register_file dut (
      .clk   (clk),
      .rst   (rst),
      .Rs    (Rs),
      .Rt    (Rt),
      .Rd    (Rd),
      .RW    (RW),
      .wr    (wr),
      .Rout1 (Rout1),
      .Rout2 (Rout2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [15:0] got,
                        input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      wr  = 1'b0;
      Rs  = '0;
      Rt  = '0;
      Rd  = '0;
      RW  = '0;

      // reset for two edges
      tick();
      tick();
      rst = 1'b0;
      Rs  = 4'd0;
      Rt  = 4'd2;
      #1;
      check("rst_r0", Rout1, 16'h0000);
      check("rst_r2", Rout2, 16'h0000);
      for (int i = 0; i < 16; i++) begin
         Rs = i[3:0];
         #1;
         check($sformatf("rst_all_r%0d", i), Rout1, 16'h0000);
      end

      // basic write
      Rd = 4'd10;
      RW = 16'h1B50;
      wr = 1'b1;
      tick();
      wr = 1'b0;
      Rs = 4'd10;
      #1;
      check("wr_r10", Rout1, 16'h1B50);

      // write disabled
      Rd = 4'd15;
      RW = 16'h2A00;
      wr = 1'b0;
      tick();
      Rt = 4'd15;
      #1;
      check("wdis_r15", Rout2, 16'h0000);
      check("wdis_r10", Rout1, 16'h1B50);

      // back-to-back writes with overwrite
      Rd = 4'd3;
      RW = 16'h2D50;
      wr = 1'b1;
      tick();
      Rd = 4'd9;
      RW = 16'hF612;
      Rs = 4'd3;
      Rt = 4'd10;
      tick();
      check("multi_r3", Rout1, 16'h2D50);
      check("multi_r10", Rout2, 16'h1B50);
      Rt = 4'd9;
      #1;
      check("multi_r9a", Rout2, 16'hF612);
      Rd = 4'd9;
      RW = 16'h4512;
      tick();
      wr = 1'b0;
      #1;
      check("multi_r9b", Rout2, 16'h4512);
      check("multi_r3b", Rout1, 16'h2D50);

      // same-address read/write, no bypass
      Rs = 4'd10;
      Rd = 4'd10;
      RW = 16'h0632;
      wr = 1'b1;
      #1;
      check("same_pre", Rout1, 16'h1B50);
      tick();
      wr = 1'b0;
      #1;
      check("same_post", Rout1, 16'h0632);

      // equal read addresses
      Rs = 4'd9;
      Rt = 4'd9;
      #1;
      check("eq_rout1", Rout1, 16'h4512);
      check("eq_rout2", Rout2, 16'h4512);

      // address 0 and top address are writable
      Rd = 4'd0;
      RW = 16'hA5A5;
      wr = 1'b1;
      tick();
      Rd = 4'd15;
      RW = 16'h5A5A;
      tick();
      wr = 1'b0;
      Rs = 4'd0;
      Rt = 4'd15;
      #1;
      check("edge_r0", Rout1, 16'hA5A5);
      check("edge_r15", Rout2, 16'h5A5A);

      // reset priority over write
      rst = 1'b1;
      wr  = 1'b1;
      Rd  = 4'd5;
      RW  = 16'hFFFF;
      tick();
      rst = 1'b0;
      wr  = 1'b0;
      Rs  = 4'd5;
      Rt  = 4'd10;
      #1;
      check("rprio_r5", Rout1, 16'h0000);
      check("rprio_r10", Rout2, 16'h0000);
      Rs = 4'd0;
      Rt = 4'd9;
      #1;
      check("rprio_r0", Rout1, 16'h0000);
      check("rprio_r9", Rout2, 16'h0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
